// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared definitions for the adder/subtractor family.
//
// Contents:
//   state_t    - FSM state encoding of the bit-serial unit (IDLE, RUN, DONE)
//   ST_*       - the same encodings as plain localparam constants, for code
//                that carries the state as a raw logic vector
//   OP_ADD     - value of the 'sub' control selecting A + B + C_in
//   OP_SUB     - value of the 'sub' control selecting A - B - C_in
//   cnt_width  - width of a counter that indexes the bits of an operand
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits needed to count 0 .. width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: single-bit combinational full adder.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit       (a ^ b ^ cin)
//   cout  - carry out     (majority of a, b, cin)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor.
//
// Operands are captured on an accepted start and processed LSB-first, one
// bit per clock, through a single carry flip-flop and one full adder.
// Subtraction is done as A + ~B + ~C_in, so the carry out of the MSB is the
// "not borrow" flag and the overflow rule is the same as for addition.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request to capture operands (taken only when ready=1)
//   sub        - OP_ADD: A + B + C_in, OP_SUB: A - B - C_in
//   A, B       - operands
//   C_in       - carry in (add) / borrow in (sub)
//   ready      - high in IDLE and DONE
//   busy       - high while bits are being processed
//   done       - one-cycle pulse, results valid from this cycle on
//   S          - sum / difference (partially shifted while busy)
//   C_out      - carry out (add) / not-borrow (sub)
//   V          - signed overflow
//   fsm_state  - current FSM state, for observation only
//
// Handshake: a request is taken on any rising edge where start=1 and
// ready=1; no queuing takes place, start while ready=0 is simply dropped,
// and A/B/sub/C_in only matter on that accepting edge. The result belongs
// to the most recent accepted request and is held until the next accept.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic [1:0]       fsm_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_next;
  logic             accept;
  logic             last_step;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_next)
  );

  assign ready     = (state != ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

  assign accept    = ready && start;
  assign last_step = (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            a_sr  <= A;
            // Subtract as A + ~B + ~C_in: inverting the borrow-in turns it
            // into the "+1" of the two's complement of B when C_in=0.
            b_sr  <= (sub == OP_SUB) ? ~B : B;
            carry <= (sub == OP_SUB) ? ~C_in : C_in;
            cnt   <= '0;
            S     <= '0;
            C_out <= 1'b0;
            V     <= 1'b0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // Sum bits enter at the MSB so that after WIDTH shifts the first
          // (LSB) bit has travelled down to S[0].
          S     <= {sum_bit, S[WIDTH-1:1]};
          carry <= carry_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            C_out <= carry_next;
            // Overflow: carry into the MSB differs from carry out of it.
            V     <= carry ^ carry_next;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  localparam int WIDTH = 4;
  localparam int RW    = WIDTH + 2;   // {S, C_out, V}

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             V;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .S         (S),
    .C_out     (C_out),
    .V         (V),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pushed = 0;
  int            n_flushed = 0;
  int            n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: done=1 with no pending op at cycle %0d", cycle);
      end else begin
        check("result_S_Cout_V", {26'd0, S, C_out, V}, {26'd0, exp_q.pop_front()});
        check("done_latency", cycle, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Waits for ready at a falling edge, presents one request for one edge.
  // The expected done cycle is the cycle after edge (accept + WIDTH).
  task automatic do_op(input logic op_sub, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin,
                       input logic [RW-1:0] exp, output logic [1:0] st_at_accept);
    int guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: ready=%b required 1", ready);
    end
    st_at_accept = fsm_state;
    start = 1'b1;
    sub   = op_sub;
    A     = a;
    B     = b;
    C_in  = cin;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cycle + 1 + WIDTH);
    n_pushed++;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 'x;
    B     = 'x;
    sub   = 1'bx;
    C_in  = 1'bx;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d ops pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [1:0] st;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    C_in  = 1'b0;

    #12;
    check("reset_ready", ready, 1);
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_S",     S,     0);
    check("reset_Cout",  C_out, 0);
    check("reset_V",     V,     0);
    check("reset_state", fsm_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain add
    do_op(1'b0, 4'b0010, 4'b0001, 1'b0, {4'b0011, 1'b0, 1'b0}, st);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", ready, 0);
    wait_idle();

    // 2: add overflow cases
    do_op(1'b0, 4'b1000, 4'b1000, 1'b0, {4'b0000, 1'b1, 1'b1}, st);
    do_op(1'b0, 4'b0111, 4'b0001, 1'b0, {4'b1000, 1'b0, 1'b1}, st);
    wait_idle();

    // 3: carry-in, then a back-to-back subtract taken in the DONE cycle
    do_op(1'b0, 4'b1111, 4'b0000, 1'b1, {4'b0000, 1'b1, 1'b0}, st);
    do_op(1'b1, 4'b0010, 4'b0001, 1'b0, {4'b0001, 1'b1, 1'b0}, st);
    check("back_to_back_from_DONE", st, 2);
    check("b2b_busy", busy, 1);
    wait_idle();

    // 4: subtract edges
    do_op(1'b1, 4'b0000, 4'b0001, 1'b0, {4'b1111, 1'b0, 1'b0}, st);
    do_op(1'b1, 4'b1000, 4'b0001, 1'b0, {4'b0111, 1'b1, 1'b1}, st);
    do_op(1'b1, 4'b0101, 4'b0011, 1'b1, {4'b0001, 1'b1, 1'b0}, st);
    wait_idle();
    check("held_S_after_done", S, 4'b0001);
    check("idle_after_done", fsm_state, 0);

    // 5: start pulses during RUN are ignored
    n_done = 0;
    do_op(1'b0, 4'b0011, 4'b0100, 1'b0, {4'b0111, 1'b0, 1'b0}, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_during_run", busy, 1);
      start = 1'b1;
      sub   = 1'b1;
      A     = 4'b1111;
      B     = 4'b0110;
      C_in  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("single_done_pulse", n_done, 1);

    // 6: asynchronous reset two cycles into RUN
    do_op(1'b0, 4'b0110, 4'b0011, 1'b0, {4'b1001, 1'b0, 1'b1}, st);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    n_flushed++;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_busy",  busy,  0);
    check("midrst_done",  done,  0);
    check("midrst_S",     S,     0);
    check("midrst_Cout",  C_out, 0);
    check("midrst_V",     V,     0);
    n_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_done_after_reset", n_done, 0);

    do_op(1'b1, 4'b0011, 4'b0110, 1'b0, {4'b1101, 1'b0, 1'b0}, st);
    check("fresh_op_from_IDLE", st, 0);
    wait_idle();
    check("fresh_op_done_count", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial N-bit adder/subtractor. It is the sequential counterpart to the team's combinational ripple adder and provides the subtract direction.
- Operands are latched on a start handshake and processed LSB-first, one bit per clock, through a single carry/borrow flip-flop.
- S, C_out and V are produced with the same meaning as the parallel adder's outputs.
- Used where area matters more than latency, and as a cross-check reference for the parallel adder.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request: sample operands this cycle (accepted only when ready=1).
sub  input  1  0 = add (A + B + C_in), 1 = subtract (A - B - C_in).
A  input  WIDTH  operand A (two's complement or unsigned).
B  input  WIDTH  operand B.
C_in  input  1  carry-in (add) / borrow-in (sub).
ready  output  1  high in IDLE and DONE; start is accepted only when high.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse: results are valid from this cycle onward.
S  output  WIDTH  sum / difference.
C_out  output  1  carry-out (add); not-borrow (sub): 1 means A >= B + C_in, unsigned.
V  output  1  signed overflow.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low (rst_n), and fixed as such.
- Reset values while rst_n = 0: state=IDLE, ready=1, busy=0, done=0, S=0, C_out=0, V=0, internal shift registers and counter = 0.
- States:
  - IDLE: ready=1.
  - RUN: busy=1, ready=0.
  - DONE: done=1, ready=1, lasts exactly one cycle.
- Accept:
  - On a rising edge with ready=1 and start=1, latch a_sr=A and b_sr=(sub ? ~B : B).
  - Set carry = (sub ? ~C_in : C_in), bit counter=0, state → RUN.
  - Clear S, C_out and V at accept.
- RUN, each edge:
  - Compute sum bit = a_sr[0] ^ b_sr[0] ^ carry.
  - Shift the sum bit into S from the MSB side, so the LSB lands in S[0] after WIDTH shifts.
  - carry ← majority(a_sr[0], b_sr[0], carry).
  - Shift a_sr and b_sr right by one; counter increments.
  - At the step where counter = WIDTH-1 (the MSB step):
    - C_out ← the new carry.
    - V ← carry-into-MSB XOR carry-out-of-MSB.
    - state → DONE.
- Latency: start accepted at edge k; done=1 in the cycle after edge k+WIDTH. S, C_out and V are stable from that cycle and held until the next accept.
- DONE → IDLE on the next edge, unless start=1 on that edge, which is accepted as a back-to-back op (DONE → RUN).
- Ignored inputs:
  - start while busy=1 is ignored; no queuing and no error flag.
  - A, B, sub and C_in are don't-care outside the accept edge.
- Reset mid-operation: rst_n low in RUN or DONE immediately forces reset values. The partial result is discarded and done does not pulse.
- Arithmetic wrap: the result is modulo 2^WIDTH. C_out and V both follow standard two's-complement rules, e.g. 0-1 → S=all ones, C_out=0.
- Intermediate values: S may show partially shifted bits while busy=1. The bench must only check S, C_out and V when done=1 or later.

Decomposition:
- Shared package add_sub_pkg:
  - State enum (IDLE, RUN, DONE).
  - Function cnt_width(WIDTH) = $clog2(WIDTH).
  - Op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- One natural sub-module, full_adder_bit: single-bit combinational full adder. Reuse the codebase's existing one-bit adder if its ports match.
- FSM, shift registers and counter stay in serial_add_sub.

Test Plan:
1. Add, WIDTH=4, A=0010 B=0001 C_in=0 → done 5 cycles after accept; S=0011, C_out=0, V=0.
2. Add overflow: A=1000 B=1000 C_in=0 → S=0000, C_out=1, V=1; then A=0111 B=0001 → S=1000, C_out=0, V=1.
3. Add with carry-in: A=1111 B=0000 C_in=1 → S=0000, C_out=1, V=0. Then start held high in the DONE cycle with sub=1 A=0010 B=0001 C_in=0 → accepted back-to-back, S=0001, C_out=1, V=0.
4. Subtract edges:
   - A=0000 B=0001 → S=1111, C_out=0, V=0.
   - A=1000 B=0001 → S=0111, C_out=1, V=1.
   - A=0101 B=0011 C_in=1 → S=0001, C_out=1.
5. Busy protection: pulse start with new operands at cycles 1..3 of RUN → ignored; result equals the first operands, exactly one done pulse.
6. Reset mid-op: assert rst_n=0 asynchronously (between edges) two cycles into RUN → outputs immediately 0, ready=1, no done pulse; a fresh op after release computes correctly.
